// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding,
// access-size codes and the byte-lane width.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RMW_WR,
    RESP
  } lsu_state_e;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;
  localparam int   LANE_W    = 8;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper: zero-extended lane extract for byte loads
// and lane merge for read-modify-write byte stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2*LANE_W-1:0] word,
  input  logic                bsel,
  input  logic [LANE_W-1:0]   wbyte,
  output logic [2*LANE_W-1:0] rd,
  output logic [2*LANE_W-1:0] merged
);

  // Select lane bsel for extraction and replacement
  always_comb begin
    rd     = '0;
    merged = word;
    if (bsel) begin
      rd[LANE_W-1:0]          = word[2*LANE_W-1:LANE_W];
      merged[2*LANE_W-1:LANE_W] = wbyte;
    end else begin
      rd[LANE_W-1:0]     = word[LANE_W-1:0];
      merged[LANE_W-1:0] = wbyte;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end for a 1-cycle synchronous data memory.
// Optional byte access (RMW byte stores) under LSU_BYTE_ACCESS_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_size,
  input  logic              req_bsel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] load_word;
  logic              byte_q;

`ifdef LSU_BYTE_ACCESS_EN
  logic              bsel_q;
  logic [DATA_W-1:0] lane_rd;
  logic [DATA_W-1:0] lane_mrg;

  lsu_byte_lane u_lane (
    .word   (mem_rdata),
    .bsel   (bsel_q),
    .wbyte  (wdata_q[LANE_W-1:0]),
    .rd     (lane_rd),
    .merged (lane_mrg)
  );

  assign load_word = byte_q ? lane_rd : mem_rdata;

  // Latch size and lane alongside the request
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q <= 1'b0;
      bsel_q <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      byte_q <= (req_size == SIZE_BYTE);
      bsel_q <= req_bsel;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{req_size, req_bsel};
  assign byte_q     = 1'b0;
  assign load_word  = mem_rdata;
`endif

  assign req_ready = (state == IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Write strobe is gated by rst so a reset can never leak a write
  assign mem_we = !rst &&
                  ((state == ISSUE && we_q && !byte_q) ||
                   (state == RMW_WR));

  // Request capture, sequencing and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q && !byte_q) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
`ifdef LSU_BYTE_ACCESS_EN
          if (we_q) begin
            wdata_q <= lane_mrg;
            state   <= RMW_WR;
          end else
`endif
          begin
            rsp_valid <= 1'b1;
            rsp_rdata <= load_word;
            state     <= RESP;
          end
        end
`ifdef LSU_BYTE_ACCESS_EN
        RMW_WR: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          state     <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 256x16 memory model.
// Byte-access vectors follow LSU_BYTE_ACCESS_EN.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        req_size, req_bsel;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [256];

  typedef struct {
    logic [15:0] data;
    int          lat;
    int          k;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cyc = -10;
  logic        prev_valid = 1'b0;
  logic [15:0] held = '0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .req_bsel  (req_bsel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop expectation at each new response, then hold check
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got %0h expected none",
                 rsp_rdata);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.data);
        chk("rsp_latency", cyc - e.k, e.lat);
        held = rsp_rdata;
      end
    end else if (rsp_valid && prev_valid) begin
      chk("rsp_hold", rsp_rdata, held);
    end
    if (rsp_valid && rsp_ready) done_cyc = cyc;
    prev_valid = rsp_valid;
  end

  task automatic issue(input logic        we,
                       input logic        size,
                       input logic        bsel,
                       input logic [7:0]  addr,
                       input logic [15:0] wdata,
                       input logic [15:0] exp,
                       input int          lat,
                       input bit          push,
                       input bit          b2b);
    int n = 0;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_bsel  = bsel;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
    end else begin
      if (b2b) chk("b2b_accept", cyc, done_cyc + 1);
      if (push) begin
        e.data = exp;
        e.lat  = lat;
        e.k    = cyc;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = 1'b0;
    req_bsel  = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, i[7:0]};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_we", mem_we, 0);

    // 1: word store then load
    issue(1, 0, 0, 8'h10, 16'hBEEF, 16'h0000, 2, 1, 0);
    issue(0, 0, 0, 8'h10, 16'h0000, 16'hBEEF, 3, 1, 0);
    wait_idle();

    // 2: stalled core holds the response
    rsp_ready = 1'b0;
    issue(0, 0, 0, 8'h40, 16'h0000, 16'hA540, 3, 1, 0);
    begin
      int n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_mem_we", mem_we, 0);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // 3: reset during ISSUE of a store drops it
    issue(1, 0, 0, 8'h20, 16'h1234, 16'h0000, 2, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_issue_mem_we", mem_we, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", rsp_valid, 0);
    chk("post_rst_ready", req_ready, 1);
    issue(0, 0, 0, 8'h20, 16'h0000, 16'hA520, 3, 1, 0);
    wait_idle();

    // 4: back-to-back loads at both address extremes
    issue(0, 0, 0, 8'h00, 16'h0000, 16'hA500, 3, 1, 0);
    issue(0, 0, 0, 8'hFF, 16'h0000, 16'hA5FF, 3, 1, 1);
    wait_idle();

    // 5/6: byte store into a word
    issue(1, 0, 0, 8'h30, 16'hA1B2, 16'h0000, 2, 1, 0);
`ifdef LSU_BYTE_ACCESS_EN
    issue(1, 1, 1, 8'h30, 16'h005C, 16'h0000, 4, 1, 0);
    issue(0, 0, 0, 8'h30, 16'h0000, 16'h5CB2, 3, 1, 0);
    issue(0, 1, 0, 8'h30, 16'h0000, 16'h00B2, 3, 1, 0);
`else
    issue(1, 1, 1, 8'h30, 16'h005C, 16'h0000, 2, 1, 0);
    issue(0, 0, 0, 8'h30, 16'h0000, 16'h005C, 3, 1, 0);
    issue(0, 1, 0, 8'h30, 16'h0000, 16'h005C, 3, 1, 0);
`endif
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
